// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the single memory bus between the instruction-fetch port and the CPU data port.
// Each port holds one buffered request; one bus transaction is in flight at a time.
module cpu_mem_arbiter #(
  parameter bit FAIR = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_request,
  input  logic [31:0] cpu_address,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_valid,
  output logic        cpu_mem_busy,
  input  logic        ifetch_request,
  input  logic [31:0] ifetch_address,
  output logic [31:0] ifetch_rdata,
  output logic        ifetch_valid,
  output logic        ifetch_busy,
  output logic        mem_request,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        protocol_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  state_t      state_r;
  state_t      state_next_s;
  logic        cpu_pend_r;
  logic [31:0] cpu_addr_r;
  logic        cpu_write_r;
  logic [3:0]  cpu_wstrb_r;
  logic [31:0] cpu_wdata_r;
  logic        if_pend_r;
  logic [31:0] if_addr_r;
  logic        owner_r;
  logic        last_owner_r;
  logic        grant_s;
  logic        start_s;
  logic        done_s;

  assign start_s      = (state_r == ST_IDLE) && (cpu_pend_r || if_pend_r);
  assign done_s       = (state_r == ST_WAIT) && mem_rvalid;
  assign cpu_mem_busy = cpu_pend_r;
  assign ifetch_busy  = if_pend_r;

  // Next-state and grant selection
  always_comb begin
    state_next_s = state_r;
    grant_s      = OWNER_FETCH;
    case (state_r)
      ST_IDLE: begin
        if (cpu_pend_r && if_pend_r) begin
          // round-robin hands the tie to whichever port did not complete last
          grant_s = FAIR ? ~last_owner_r : OWNER_DATA;
        end else if (cpu_pend_r) begin
          grant_s = OWNER_DATA;
        end else begin
          grant_s = OWNER_FETCH;
        end
        if (cpu_pend_r || if_pend_r) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register and grant bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWNER_FETCH;
      last_owner_r <= OWNER_FETCH;
    end else begin
      state_r <= state_next_s;
      if (start_s) begin
        owner_r <= grant_s;
      end
      if (done_s) begin
        last_owner_r <= owner_r;
      end
    end
  end

  // Per-port request buffers and the sticky protocol error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_pend_r     <= 1'b0;
      cpu_addr_r     <= 32'd0;
      cpu_write_r    <= 1'b0;
      cpu_wstrb_r    <= 4'd0;
      cpu_wdata_r    <= 32'd0;
      if_pend_r      <= 1'b0;
      if_addr_r      <= 32'd0;
      protocol_error <= 1'b0;
    end else begin
      if (cpu_request && !cpu_pend_r) begin
        cpu_pend_r  <= 1'b1;
        cpu_addr_r  <= cpu_address;
        cpu_write_r <= cpu_write;
        cpu_wstrb_r <= cpu_wstrb;
        cpu_wdata_r <= cpu_wdata;
      end else if (done_s && (owner_r == OWNER_DATA)) begin
        cpu_pend_r <= 1'b0;
      end
      if (ifetch_request && !if_pend_r) begin
        if_pend_r <= 1'b1;
        if_addr_r <= ifetch_address;
      end else if (done_s && (owner_r == OWNER_FETCH)) begin
        if_pend_r <= 1'b0;
      end
      if ((cpu_request && cpu_pend_r) || (ifetch_request && if_pend_r)) begin
        protocol_error <= 1'b1;
      end
    end
  end

  // Bus-side registers, loaded once at grant so they hold through ISSUE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_request <= 1'b0;
      mem_address <= 32'd0;
      mem_write   <= 1'b0;
      mem_wstrb   <= 4'd0;
      mem_wdata   <= 32'd0;
    end else begin
      mem_request <= (state_next_s == ST_ISSUE);
      if (start_s) begin
        if (grant_s == OWNER_DATA) begin
          mem_address <= cpu_addr_r;
          mem_write   <= cpu_write_r;
          mem_wstrb   <= cpu_wstrb_r;
          mem_wdata   <= cpu_wdata_r;
        end else begin
          mem_address <= if_addr_r;
          mem_write   <= 1'b0;
          mem_wstrb   <= 4'd0;
          mem_wdata   <= 32'd0;
        end
      end
    end
  end

  // Completion routing back to the owning port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_valid    <= 1'b0;
      ifetch_valid <= 1'b0;
      cpu_rdata    <= 32'd0;
      ifetch_rdata <= 32'd0;
    end else begin
      cpu_valid    <= done_s && (owner_r == OWNER_DATA);
      ifetch_valid <= done_s && (owner_r == OWNER_FETCH);
      if (done_s && (owner_r == OWNER_DATA)) begin
        cpu_rdata <= mem_rdata;
      end
      if (done_s && (owner_r == OWNER_FETCH)) begin
        ifetch_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares the single memory bus between the instruction-fetch port and the CPU data port, the load/store interface driven by the ALU stage. Each port gets a one-entry request buffer. A small FSM grants one transaction at a time and allows one outstanding transaction. Completions are routed back to the owning port as a registered `valid` pulse with held read data. Sits between the CPU core and the memory/bus interconnect.

## Interface
- `FAIR`, default 0: tie-break when both ports are pending. 0 = data port always wins; 1 = round-robin (grant the port not granted last).
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `cpu_request`  in  1  data-port request pulse, sampled on clock edge
- `cpu_address`  in  32  data address, valid with `cpu_request`
- `cpu_write`  in  1  1 = store, valid with `cpu_request`
- `cpu_wstrb`  in  4  byte strobes, valid with `cpu_request`
- `cpu_wdata`  in  32  store data, valid with `cpu_request`
- `cpu_rdata`  out  32  load data; held until the next data completion
- `cpu_valid`  out  1  one-cycle pulse, data transaction complete (loads and stores)
- `cpu_mem_busy`  out  1  data buffer occupied
- `ifetch_request`  in  1  fetch request pulse
- `ifetch_address`  in  32  fetch address
- `ifetch_rdata`  out  32  fetch data; held until the next fetch completion
- `ifetch_valid`  out  1  one-cycle pulse, fetch complete
- `ifetch_busy`  out  1  fetch buffer occupied
- `mem_request`  out  1  bus request
- `mem_address`  out  32  bus address
- `mem_write`  out  1  bus write
- `mem_wstrb`  out  4  bus strobes (fetch: 4'b0000)
- `mem_wdata`  out  32  bus write data
- `mem_ready`  in  1  bus accepts request this cycle
- `mem_rvalid`  in  1  completion of accepted transaction (every read and write)
- `mem_rdata`  in  32  read data, valid with `mem_rvalid`
- `protocol_error`  out  1  sticky: request arrived while that port's buffer was full

## Operation
- Buffers:
  - Each port has a pending bit plus its captured fields (address, write, wstrb, wdata).
  - A request pulse with the pending bit clear loads the buffer and sets the pending bit.
  - A request pulse with the pending bit set is dropped, and `protocol_error` is set.
  - `cpu_mem_busy` and `ifetch_busy` equal the respective pending bits.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if any port is pending, select the owner per `FAIR`, record it, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `mem_request`=1. `mem_*` fields are driven from the owner's buffer and stay stable. On `mem_ready`=1 go to WAIT.
  - WAIT: `mem_request`=0. On `mem_rvalid`=1:
    - capture `mem_rdata` into the owner's rdata register;
    - clear the owner's pending bit;
    - set the owner's valid for the next cycle;
    - update the last-owner register;
    - go to IDLE.
- `mem_rvalid` outside WAIT is ignored.
- Fetch transactions drive `mem_write`=0, `mem_wstrb`=0, `mem_wdata`=0.
- Reset values: state IDLE; both pending bits 0; last-owner = ifetch, so the first tie goes to data; all outputs 0, including rdata registers and `protocol_error`.
- Reset during ISSUE or WAIT abandons the transaction. A late `mem_rvalid` after reset is ignored, and no `valid` pulse is produced.

## Timing
- Request sampled at edge N: pending=1 in cycle N+1, ISSUE in N+2 (`mem_request` high).
- If `mem_ready` is 1 in N+2, the FSM is in WAIT from N+3.
- If `mem_rvalid` is 1 in cycle M, then `*_valid`=1 in M+1 and rdata is valid from M+1.
- Minimum request-to-valid latency is 4 cycles; M ≥ N+3.
- `*_busy` falls in the same cycle `*_valid` rises. A new request sampled at the end of that cycle is accepted without error.
- Simultaneous requests from both ports at the same edge: both are captured, and grants are serialised per `FAIR`.
- The losing port is granted at the first IDLE after the winner completes. Its request goes out in the cycle after the winner's valid pulse.
- `mem_ready` may stay low indefinitely; bus fields must hold stable throughout ISSUE.
- No combinational path from any input to any output.

## Test plan
- Single load:
  - Stimulus: `cpu_request` at edge 0, address 0x100, write 0; `mem_ready` immediate; `mem_rvalid` 2 cycles after accept, data 0xDEADBEEF.
  - Required: `mem_request` high exactly one cycle with `mem_address`=0x100; then `cpu_valid` one-cycle pulse with `cpu_rdata`=0xDEADBEEF held after.
- Store with stall:
  - Stimulus: STW to 0x200, wstrb 4'b1111, wdata 0x12345678; `mem_ready` low for 3 cycles.
  - Required: bus fields stable for 4 ISSUE cycles; `cpu_valid` pulses after `mem_rvalid`; `cpu_mem_busy` high until then.
- Tie with FAIR=0:
  - Stimulus: both ports request at the same edge, three times in a row.
  - Required: data is granted first every time; fetch completes after each.
- Tie with FAIR=1:
  - Stimulus: repeated simultaneous requests.
  - Required: grants alternate data, ifetch, data, ifetch.
- Protocol error:
  - Stimulus: second `ifetch_request` while `ifetch_busy`=1.
  - Required: request dropped, `protocol_error`=1 and stays set; the original fetch completes normally.
- Reset in WAIT:
  - Stimulus: assert `reset` asynchronously mid-WAIT, release, then drive `mem_rvalid`.
  - Required: all outputs 0 immediately; no `valid` pulse; the next request completes normally.
